// File: rtl/rr_enc16.sv
// rr_enc16 -- sequential round-robin encoder for N pulsed request lines.
//
// Request pulses are OR-ed into a pending register. One pending index at a
// time is presented on code/valid. The consumer takes it with ready. The
// search for the next grant starts one past the last accepted index, so every
// pending line is served within N accepts.
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst       in   synchronous, active-high reset
//   e         in   capture enable for req (pending state kept when low)
//   req       in   [0:N-1] request lines, req[i] asks for code i
//   ready     in   consumer accepts the presented code this cycle
//   valid     out  code holds a pending request index
//   code      out  [W-1:0] granted index
//   pend_cnt  out  [W:0] number of pending requests (0..N)

module rr_enc16 #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           e,
  input  logic [0:N-1]   req,
  input  logic           ready,
  output logic           valid,
  output logic [W-1:0]   code,
  output logic [W:0]     pend_cnt
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         valid_q, valid_d;
  logic [W-1:0] code_q, code_d;
  logic [W:0]   cnt_q, cnt_d;

  logic         accept;
  logic [N-1:0] clr;
  logic [N-1:0] set;
  logic         found;
  logic [W-1:0] sel;
  logic [W-1:0] idx;

  always_comb begin
    accept = valid_q & ready;

    clr = '0;
    if (accept) clr[code_q] = 1'b1;

    set = '0;
    for (int i = 0; i < N; i++) set[i] = e & req[i];

    // Set is applied after clear so a re-asserted served bit stays armed.
    pend_d = (pend_q & ~clr) | set;

    // W-bit add wraps N-1 back to 0.
    ptr_d = accept ? code_q + W'(1) : ptr_q;

    cnt_d = '0;
    for (int i = 0; i < N; i++) cnt_d = cnt_d + (W+1)'(pend_d[i]);

    // Rotating priority search starting at ptr_d, wrapping through 0.
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_d + W'(k);
      if (!found && pend_d[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    // Under backpressure the presented code must not move.
    valid_d = valid_q;
    code_d  = code_q;
    if (!valid_q || ready) begin
      valid_d = found;
      code_d  = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid    = valid_q;
  assign code     = code_q;
  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_rr_enc16.sv
module tb_rr_enc16;

  logic        clk;
  logic        rst;
  logic        e;
  logic [0:15] req;
  logic        ready;
  logic        valid;
  logic [3:0]  code;
  logic [4:0]  pend_cnt;

  int errors = 0;
  int checks = 0;

  // reference state
  bit [15:0] m_pend;
  int        m_ptr;
  bit        m_valid;
  int        m_code;
  int        m_cnt;

  rr_enc16 dut (
    .clk      (clk),
    .rst      (rst),
    .e        (e),
    .req      (req),
    .ready    (ready),
    .valid    (valid),
    .code     (code),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference step from the behavioural rules, using pre-edge model state.
  task automatic model_step(input bit r, input bit en, input bit [15:0] m, input bit rdy);
    bit [15:0] np;
    int        nptr;
    bit        acc;
    if (r) begin
      m_pend = '0; m_ptr = 0; m_valid = 0; m_code = 0; m_cnt = 0;
      return;
    end
    acc = m_valid && rdy;
    np  = m_pend;
    if (acc) np[m_code] = 1'b0;
    if (en) np = np | m;
    nptr = acc ? (m_code + 1) % 16 : m_ptr;
    if (!m_valid || rdy) begin
      m_valid = (np != 0);
      m_code  = 0;
      for (int k = 0; k < 16; k++) begin
        if (np[(nptr + k) % 16]) begin
          m_code = (nptr + k) % 16;
          break;
        end
      end
    end
    m_pend = np;
    m_ptr  = nptr;
    m_cnt  = $countones(np);
  endtask

  task automatic cycle(input bit r, input bit en, input bit [15:0] m, input bit rdy);
    rst = r; e = en; ready = rdy;
    for (int i = 0; i < 16; i++) req[i] = m[i];
    @(posedge clk);
    model_step(r, en, m, rdy);
    #1;
    chk("valid", int'(valid), int'(m_valid));
    chk("code", int'(code), m_code);
    chk("pend_cnt", int'(pend_cnt), m_cnt);
  endtask

  task automatic expect_out(input string tag, input int v, input int c, input int n);
    chk({tag, ".valid"}, int'(valid), v);
    chk({tag, ".code"}, int'(code), c);
    chk({tag, ".cnt"}, int'(pend_cnt), n);
  endtask

  initial begin
    bit [31:0] rnd;
    bit [15:0] m;
    rst = 1'b1; e = 1'b0; req = '0; ready = 1'b0;

    cycle(1, 0, 16'h0000, 0);
    expect_out("reset", 0, 0, 0);

    // single request
    cycle(0, 1, 16'h0020, 1);
    expect_out("single", 1, 5, 1);
    cycle(0, 1, 16'h0000, 1);
    expect_out("single_done", 0, 0, 0);

    // capture disabled
    repeat (3) begin
      cycle(0, 0, 16'hFFFF, 1);
      expect_out("e_low", 0, 0, 0);
    end

    // multi-hot burst from ptr 0
    cycle(1, 0, 16'h0000, 0);
    cycle(0, 1, 16'h1208, 1);
    expect_out("burst0", 1, 3, 3);
    cycle(0, 0, 16'h0000, 1);
    expect_out("burst1", 1, 9, 2);
    cycle(0, 0, 16'h0000, 1);
    expect_out("burst2", 1, 12, 1);
    cycle(0, 0, 16'h0000, 1);
    expect_out("burst_end", 0, 0, 0);

    // backpressure hold (ptr is 13, search wraps to 2)
    cycle(0, 1, 16'h0084, 0);
    expect_out("hold0", 1, 2, 2);
    repeat (3) begin
      cycle(0, 0, 16'h0000, 0);
      expect_out("hold", 1, 2, 2);
    end
    cycle(0, 0, 16'h0000, 1);
    expect_out("hold_rel", 1, 7, 1);
    cycle(0, 0, 16'h0000, 1);
    expect_out("hold_end", 0, 0, 0);

    // wrap 15 -> 1 after serving 14
    cycle(0, 1, 16'h4000, 1);
    expect_out("wrap14", 1, 14, 1);
    cycle(0, 1, 16'h8002, 1);
    expect_out("wrap15", 1, 15, 2);
    cycle(0, 0, 16'h0000, 1);
    expect_out("wrap1", 1, 1, 1);
    cycle(0, 0, 16'h0000, 1);
    expect_out("wrap_end", 0, 0, 0);

    // reset mid-stream
    cycle(0, 1, 16'h1111, 0);
    expect_out("pre_rst", 1, 4, 4);
    cycle(1, 1, 16'hFFFF, 1);
    expect_out("mid_rst", 0, 0, 0);
    cycle(0, 1, 16'h0001, 1);
    expect_out("post_rst", 1, 0, 1);
    cycle(0, 0, 16'h0000, 1);

    // set wins over clear on the accepted bit
    cycle(1, 0, 16'h0000, 0);
    cycle(0, 1, 16'h0040, 0);
    expect_out("rearm0", 1, 6, 1);
    cycle(0, 1, 16'h0040, 1);
    expect_out("rearm1", 1, 6, 1);
    cycle(0, 0, 16'h0000, 1);
    expect_out("rearm_end", 0, 0, 0);

    // full pending register, then accept with e=0
    cycle(1, 0, 16'h0000, 0);
    cycle(0, 1, 16'hFFFF, 0);
    expect_out("full", 1, 0, 16);
    cycle(0, 0, 16'h0000, 1);
    expect_out("full_acc", 1, 1, 15);

    // randomized traffic against the reference
    for (int n = 0; n < 800; n++) begin
      rnd = $urandom;
      case ($urandom_range(0, 3))
        0: m = rnd[15:0];
        1: m = 16'h0001 << $urandom_range(0, 15);
        2: m = rnd[15:0] & rnd[31:16];
        default: m = 16'h0000;
      endcase
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), m,
            ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
